avr_fetch: RTL and testbench
============================

# avr_fetch

Instruction fetch stage between the synchronous program flash and the AVR core decode stage. It generates flash word addresses and holds prefetched words in a small tagged buffer. It presents one complete instruction per cycle to decode, either a single 16-bit word or a 32-bit opcode delivered as both words together. Decode redirects fetch with a load strobe on branches, calls, returns and interrupts.

## Interface
- DEPTH, 4, prefetch buffer entries; power of two, ≥2
- clock  in  1  single system clock; all state on posedge
- reset  in  1  synchronous, active-high
- flash_addr  out  16  word address to flash; `= pc_load ? pc_target : fetch_ptr`
- flash_data  in  16  flash word; valid exactly one cycle after its address
- pc_load  in  1  redirect strobe from decode
- pc_target  in  16  redirect word address
- ir_ready  in  1  decode accepts the presented instruction this cycle
- ir_valid  out  1  ir/ir2/ir_pc/wide hold a complete instruction
- ir  out  16  first opcode word
- ir2  out  16  second word of a 32-bit opcode; 0 otherwise
- ir_pc  out  16  word address of ir
- wide  out  1  current instruction is 32-bit

## Operation
- State:
  - fetch_ptr (16b).
  - inflight flag plus tag of the address issued last cycle.
  - FIFO of {word, pc}, count 0..DEPTH.
- Issue:
  - A read is issued in cycle t when count + inflight < DEPTH, or whenever pc_load=1.
  - Issuing sets fetch_ptr ← flash_addr+1, wrapping 0xFFFF→0x0000, and sets inflight.
  - With no issue, flash_addr still shows fetch_ptr, but the response is not captured.
- Capture: when inflight is set and not cancelled, flash_data with its tag is pushed into the FIFO.
- Credit check ignores same-cycle pops (conservative). Overflow is impossible by construction.
- Wide detection: (w & 0xFC0F)==0x9000 (LDS/STS) or (w & 0xFE0C)==0x940C (JMP/CALL).
- Output:
  - ir_valid=1 when head is narrow and count≥1, or head is wide and count≥2.
  - ir=head.word, ir_pc=head.pc, ir2=next.word when wide else 0.
- Pop: ir_valid & ir_ready pops 1 entry (narrow) or 2 entries (wide).
- Redirect (pc_load=1):
  - FIFO flushed and any in-flight response discarded.
  - Read issued at pc_target in the same cycle.
  - A concurrent pop is ignored.
- Second word at 0xFFFF wraps to 0x0000; ir_pc of the next instruction wraps identically.
- pc_load is honoured even while ir_valid=0.

## Timing
- Reset values:
  - ir_valid=0, ir=ir2=ir_pc=0, wide=0.
  - fetch_ptr=0, count=0, inflight=0.
  - flash_addr=0 while reset is held.
- First cycle after reset: issue addr 0.
- Latency, issue to valid:
  - Narrow: 2 cycles (issue t, capture at edge ending t+1, ir_valid in t+2).
  - Wide: 3 cycles from cold.
- Redirect in cycle N: ir_valid=0 in N+1; target instruction valid in N+2 (narrow).
- Steady state with ir_ready=1: one narrow instruction per cycle, no bubbles.
- Reset mid-operation overrides pc_load, pops and captures. Everything returns to reset values next cycle.

## Configuration
- AVR_FETCH_WIDE_EN:
  - Defined: wide detection as above; 32-bit opcodes delivered atomically.
  - Undefined: every word is treated as narrow; wide=0, ir2=0, one pop per accept. Decode then fetches second words itself.

## Structure
- Shared package avr_pkg holds:
  - WIDE_LDS_MASK/VAL (0xFC0F/0x9000), WIDE_JMP_MASK/VAL (0xFE0C/0x940C).
  - An is_wide function.
  - The word/pc entry typedef.
- Sub-module avr_fetch_fifo: tagged FIFO with push, pop1, pop2, flush, count, head/next outputs.

## Test plan
- Release reset; flash[0]=0x0000: ir_valid rises 2 cycles after the first post-reset edge with ir=0x0000, ir_pc=0.
- ir_ready held 1, flash[0..7] narrow: one instruction per cycle, ir_pc 0,1,…,7, no gaps.
- flash[5]=0x940C, flash[6]=0x0100: ir=0x940C, ir2=0x0100, wide=1, ir_pc=5; next ir_pc=7.
- ir_ready=0 for 10 cycles: flash_addr stops advancing at count=4; on release, ir_pc continues 0,1,2,… with no loss or duplication.
- pc_load, pc_target=0x0200, in the same cycle as an accept and a capture: ir_valid=0 next cycle, then ir_pc=0x0200 with ir=flash[0x200].
- pc_load to 0xFFFF where flash[0xFFFF]=0x9000:
  - Macro on: ir2=flash[0], next ir_pc=0x0001.
  - Macro off: wide=0, next ir_pc=0x0000.

Source files
------------

// File: rtl/avr_pkg.sv
// avr_pkg: shared definitions for the AVR instruction fetch stage.
//   - opcode masks/values that identify 32-bit (two-word) instructions
//   - is_wide(): classifies a first opcode word as 32-bit
//   - fetch_entry_t: one prefetch buffer entry {word, pc}
package avr_pkg;

    // LDS/STS: 1001 00xd dddd 0000
    localparam logic [15:0] WIDE_LDS_MASK = 16'hFC0F;
    localparam logic [15:0] WIDE_LDS_VAL  = 16'h9000;
    // JMP/CALL: 1001 010k kkkk 11xk
    localparam logic [15:0] WIDE_JMP_MASK = 16'hFE0C;
    localparam logic [15:0] WIDE_JMP_VAL  = 16'h940C;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] pc;
    } fetch_entry_t;

    function automatic logic is_wide(input logic [15:0] w);
        return ((w & WIDE_LDS_MASK) == WIDE_LDS_VAL) ||
               ((w & WIDE_JMP_MASK) == WIDE_JMP_VAL);
    endfunction

endpackage

// File: rtl/avr_fetch_fifo.sv
// avr_fetch_fifo: tagged prefetch FIFO of {word, pc} entries.
// Ports:
//   i_clock, i_reset   clock, synchronous active-high reset
//   i_push, i_data     append one entry
//   i_pop1, i_pop2     remove one / two entries from the head
//   i_flush            empty the FIFO (wins over push and pop)
//   o_count            occupancy 0..DEPTH
//   o_head             entry at the head
//   o_next_word        opcode word of the entry behind the head
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module avr_fetch_fifo
    import avr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  fetch_entry_t           i_data,
    input  logic                   i_pop1,
    input  logic                   i_pop2,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output fetch_entry_t           o_head,
    output logic [15:0]            o_next_word
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_pop_n;
    logic [AW-1:0] w_next_ptr;

    always_comb begin
        w_pop_n = '0;
        if (i_pop2)
            w_pop_n = (AW+1)'(2);
        else if (i_pop1)
            w_pop_n = (AW+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            // A pop of 2 at DEPTH=2 truncates to 0, which is the correct wrap.
            r_rd_ptr <= r_rd_ptr + w_pop_n[AW-1:0];
            r_count  <= r_count + {{AW{1'b0}}, i_push} - w_pop_n;
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by r_count, so stale contents are never observed as valid.
    always_ff @(posedge i_clock) begin
        if (i_push && !i_reset && !i_flush)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign w_next_ptr  = r_rd_ptr + AW'(1);
    assign o_count     = r_count;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_next_word = r_mem[w_next_ptr].word;

endmodule

// File: rtl/avr_fetch.sv
// avr_fetch: instruction fetch stage between synchronous program flash and
// AVR decode. Generates flash word addresses, keeps prefetched words in a
// tagged FIFO and presents one complete instruction per cycle.
// Ports:
//   clock, reset        clock, synchronous active-high reset
//   flash_addr          word address to flash (pc_target while pc_load)
//   flash_data          flash word, valid one cycle after its address
//   pc_load, pc_target  redirect strobe and target word address
//   ir_ready            decode accepts the presented instruction
//   ir_valid            ir/ir2/ir_pc/wide hold a complete instruction
//   ir, ir2, ir_pc      first word, second word (0 if narrow), address of ir
//   wide                presented instruction is 32-bit
// Build option: define AVR_FETCH_WIDE_EN to deliver 32-bit opcodes as one
// atomic instruction; otherwise every word is presented as narrow.
module avr_fetch
    import avr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] flash_addr,
    input  logic [15:0] flash_data,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    input  logic        ir_ready,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [15:0] ir2,
    output logic [15:0] ir_pc,
    output logic        wide
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   r_fetch_ptr;
    logic          r_inflight;
    logic [15:0]   r_tag;

    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic [15:0]   w_next_word;
    logic          w_issue;
    logic          w_capture;
    logic          w_head_wide;
    logic          w_accept;

    assign flash_addr = reset ? 16'h0000 : (pc_load ? pc_target : r_fetch_ptr);

    // Credit check counts the read in flight but not a same-cycle pop, so a
    // response always has a free slot when it lands.
    assign w_issue = !reset &&
                     (pc_load || ((int'(w_count) + int'(r_inflight)) < DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_ptr <= 16'h0000;
            r_inflight  <= 1'b0;
            r_tag       <= 16'h0000;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_ptr <= flash_addr + 16'd1;
                r_tag       <= flash_addr;
            end
        end
    end

    // A redirect cancels the response of the read issued last cycle.
    assign w_capture   = r_inflight && !pc_load;
    assign w_push_data = '{word: flash_data, pc: r_tag};

`ifdef AVR_FETCH_WIDE_EN
    assign w_head_wide = is_wide(w_head.word);
`else
    assign w_head_wide = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no branch can
    // leave it unassigned and infer a latch.
    always_comb begin
        ir_valid = 1'b0;
        ir       = 16'h0000;
        ir2      = 16'h0000;
        ir_pc    = 16'h0000;
        wide     = 1'b0;
        if (w_count != '0) begin
            ir    = w_head.word;
            ir_pc = w_head.pc;
            wide  = w_head_wide;
            if (!w_head_wide) begin
                ir_valid = 1'b1;
            end else if (w_count >= CW'(2)) begin
                ir_valid = 1'b1;
                ir2      = w_next_word;
            end
        end
    end

    assign w_accept = ir_valid && ir_ready && !pc_load;

    avr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_push      (w_capture),
        .i_data      (w_push_data),
        .i_pop1      (w_accept && !w_head_wide),
        .i_pop2      (w_accept && w_head_wide),
        .i_flush     (pc_load),
        .o_count     (w_count),
        .o_head      (w_head),
        .o_next_word (w_next_word)
    );

endmodule

// File: tb/tb_avr_fetch.sv
// tb_avr_fetch: directed bench for avr_fetch with an instruction-stream model.
// The model walks the program image from the current PC (one or two words per
// instruction) and is compared against every valid presented instruction.
module tb_avr_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] flash_addr;
    logic [15:0] flash_data;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        ir_ready;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir2;
    logic [15:0] ir_pc;
    logic        wide;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] flash_mem [0:65535];

`ifdef AVR_FETCH_WIDE_EN
    localparam bit WIDE = 1'b1;
`else
    localparam bit WIDE = 1'b0;
`endif

    avr_fetch #(.DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .ir_ready   (ir_ready),
        .ir_valid   (ir_valid),
        .ir         (ir),
        .ir2        (ir2),
        .ir_pc      (ir_pc),
        .wide       (wide)
    );

    always #5 clock = ~clock;

    // Synchronous flash: word appears one cycle after its address.
    always @(posedge clock) flash_data <= flash_mem[flash_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_is_wide(input logic [15:0] w);
        if (!WIDE) return 1'b0;
        return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
    endfunction

    function automatic logic [15:0] dflt(input int a);
        return 16'h1000 | 16'(a & 16'h0FFF);
    endfunction

    // ---------------- model + compare process ----------------
    logic [15:0] m_pc;
    logic        m_blank;
    bit          m_on = 1'b1;

    always @(negedge clock) begin
        logic [15:0] w0;
        logic        wd;
        if (reset) begin
            m_pc    = 16'h0000;
            m_blank = 1'b0;
        end else if (m_on) begin
            w0 = flash_mem[m_pc];
            wd = m_is_wide(w0);
            if (m_blank) begin
                check("model_redirect_bubble", {31'b0, ir_valid}, 32'd0);
            end else if (ir_valid) begin
                check("model_ir_pc", {16'h0, ir_pc}, {16'h0, m_pc});
                check("model_ir",    {16'h0, ir},    {16'h0, w0});
                check("model_wide",  {31'b0, wide},  {31'b0, wd});
                check("model_ir2",   {16'h0, ir2},
                      wd ? {16'h0, flash_mem[16'(m_pc + 16'd1)]} : 32'd0);
            end
            if (pc_load) begin
                m_pc    = pc_target;
                m_blank = 1'b1;
            end else begin
                m_blank = 1'b0;
                if (ir_valid && ir_ready)
                    m_pc = m_pc + (wd ? 16'd2 : 16'd1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic sample;
        @(negedge clock);
    endtask

    // Reset asserted together with pc_load/ir_ready to show reset dominates.
    // Returns at the start of the first cycle with reset low (C0).
    task automatic do_reset;
        reset     = 1'b1;
        pc_load   = 1'b1;
        pc_target = 16'h1234;
        ir_ready  = 1'b1;
        sample;
        check("rst_flash_addr_held", {16'h0, flash_addr}, 32'd0);
        next_cycle;
        sample;
        check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
        check("rst_ir",       {16'h0, ir},       32'd0);
        check("rst_ir2",      {16'h0, ir2},      32'd0);
        check("rst_ir_pc",    {16'h0, ir_pc},    32'd0);
        check("rst_wide",     {31'b0, wide},     32'd0);
        next_cycle;
        reset    = 1'b0;
        pc_load  = 1'b0;
        ir_ready = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            sample;
            if (ir_valid) return;
            next_cycle;
        end
        check(name, {31'b0, ir_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_ir2;
        logic [15:0] exp_next;
        bit          found;

        for (int a = 0; a < 65536; a++) flash_mem[a] = dflt(a);
        flash_mem[0]       = 16'h0000;
        flash_mem[16'hFFFF] = 16'h9000;
        flash_mem[16'h0405] = 16'h940E;   // CALL
        flash_mem[16'h0410] = 16'h9200;   // STS
        flash_mem[16'h0420] = 16'h9001;   // LD Z+, narrow
        flash_mem[16'h0430] = 16'h940C;   // JMP
        reset = 1'b1; pc_load = 1'b0; pc_target = 16'h0; ir_ready = 1'b0;
        repeat (2) next_cycle;

        // Cold start latency, then gapless narrow stream.
        do_reset;
        sample;
        check("c0_flash_addr", {16'h0, flash_addr}, 32'd0);
        check("c0_ir_valid",   {31'b0, ir_valid},   32'd0);
        next_cycle;
        sample;
        check("c1_flash_addr", {16'h0, flash_addr}, 32'd1);
        check("c1_ir_valid",   {31'b0, ir_valid},   32'd0);
        next_cycle;
        ir_ready = 1'b1;
        sample;
        check("c2_ir", {16'h0, ir}, 32'h0000);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) sample;
            check("stream_valid", {31'b0, ir_valid}, 32'd1);
            check("stream_ir_pc", {16'h0, ir_pc}, 32'(i));
            next_cycle;
        end

        // 32-bit JMP at 5; reset lands mid-stream.
        flash_mem[5] = 16'h940C;
        flash_mem[6] = 16'h0100;
        do_reset;
        ir_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            sample;
            if (ir_valid && ir_pc == 16'd5) found = 1'b1;
            else next_cycle;
        end
        check("jmp_ir_pc", {16'h0, ir_pc}, 32'd5);
        check("jmp_ir",    {16'h0, ir},    32'h940C);
        check("jmp_wide",  {31'b0, wide},  {31'b0, WIDE});
        check("jmp_ir2",   {16'h0, ir2},   WIDE ? 32'h0100 : 32'h0);
        next_cycle;
        sample;
        check("after_jmp_valid", {31'b0, ir_valid}, 32'd1);
        check("after_jmp_ir_pc", {16'h0, ir_pc}, WIDE ? 32'd7 : 32'd6);

        // Backpressure: fetch stops at 4 entries, then drains without loss.
        flash_mem[5] = dflt(5);
        flash_mem[6] = dflt(6);
        do_reset;
        for (int i = 0; i < 10; i++) begin
            sample;
            if (i >= 8) check("stall_flash_addr", {16'h0, flash_addr}, 32'd4);
            next_cycle;
        end
        ir_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample;
            check("drain_valid", {31'b0, ir_valid}, 32'd1);
            check("drain_ir_pc", {16'h0, ir_pc}, 32'(k));
            next_cycle;
        end

        // Redirect concurrent with an accept and a capture.
        pc_load   = 1'b1;
        pc_target = 16'h0200;
        sample;
        check("redir_valid_same", {31'b0, ir_valid}, 32'd1);
        check("redir_flash_addr", {16'h0, flash_addr}, 32'h0200);
        next_cycle;
        pc_load = 1'b0;
        sample;
        check("redir_bubble", {31'b0, ir_valid}, 32'd0);
        next_cycle;
        sample;
        check("redir_tgt_valid", {31'b0, ir_valid}, 32'd1);
        check("redir_tgt_ir_pc", {16'h0, ir_pc}, 32'h0200);
        check("redir_tgt_ir",    {16'h0, ir},    32'h1200);
        next_cycle;
        sample;
        check("redir_next_ir_pc", {16'h0, ir_pc}, 32'h0201);
        next_cycle;

        // Wide opcode at the top of memory: second word wraps to 0.
        pc_load   = 1'b1;
        pc_target = 16'hFFFF;
        next_cycle;
        pc_load = 1'b0;
        wait_valid("top_timeout", 8);
        exp_ir2  = WIDE ? 16'h0000 : 16'h0000;  // flash[0] holds 0x0000
        exp_next = WIDE ? 16'h0001 : 16'h0000;
        check("top_ir_pc", {16'h0, ir_pc}, 32'hFFFF);
        check("top_ir",    {16'h0, ir},    32'h9000);
        check("top_wide",  {31'b0, wide},  {31'b0, WIDE});
        check("top_ir2",   {16'h0, ir2},   {16'h0, exp_ir2});
        next_cycle;
        sample;
        check("top_next_valid", {31'b0, ir_valid}, 32'd1);
        check("top_next_ir_pc", {16'h0, ir_pc}, {16'h0, exp_next});
        next_cycle;

        // Redirect while nothing is valid yet.
        do_reset;
        pc_load   = 1'b1;
        pc_target = 16'h0300;
        sample;
        check("cold_redir_addr", {16'h0, flash_addr}, 32'h0300);
        next_cycle;
        pc_load = 1'b0;
        sample;
        check("cold_redir_bubble", {31'b0, ir_valid}, 32'd0);
        next_cycle;
        sample;
        check("cold_redir_valid", {31'b0, ir_valid}, 32'd1);
        check("cold_redir_ir_pc", {16'h0, ir_pc}, 32'h0300);
        next_cycle;

        // Mixed narrow/wide region with irregular decode backpressure.
        pc_load   = 1'b1;
        pc_target = 16'h0400;
        next_cycle;
        pc_load = 1'b0;
        for (int i = 0; i < 150; i++) begin
            ir_ready = 1'($urandom_range(0, 3) != 0);
            next_cycle;
        end
        ir_ready = 1'b1;
        sample;
        check("mixed_progress", {31'b0, (m_pc > 16'h0430)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
